// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers digit values from a multiplexed active-low 7-segment scan
module seg7_scan_decoder #(
    parameter int DIGITS  = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  frame_valid,
    output logic                  scan_err,
    output logic                  stalled
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = DIGITS + 7;
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0]     SETTLE_C    = SW'(SETTLE);
    localparam logic [TW-1:0]     TIMEOUT_C   = TW'(TIMEOUT);
    localparam logic [DIGITS-1:0] ONE_HOT0    = DIGITS'(1);

    typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        sync1_q, sync2_q;
    logic [IW-1:0]        prev_q, prev_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        stall_q, stall_d;
    logic [DIGITS-1:0]    seen_q, seen_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [DIGITS-1:0]    blank_q, blank_d;
    logic [DIGITS-1:0]    err_q, err_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 scan_err_q, scan_err_d;

    logic [DIGITS-1:0]    a;
    logic [6:0]           s;
    logic [IW-1:0]        cur;
    logic [3:0]           dec_val;
    logic                 dec_blank, dec_err;
    logic                 capture;
    logic [DIGITS-1:0]    seen_nxt;

    // Synchronizers idle at all-ones, i.e. a dark display, so release from reset is not a change.
    assign a   = ~sync2_q[IW-1:7];
    assign s   = ~sync2_q[6:0];
    assign cur = {a, s};

    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (s)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = cur;
        cnt_d         = cnt_q;
        stall_d       = (stall_q == TIMEOUT_C) ? stall_q : stall_q + TW'(1);
        seen_d        = seen_q;
        digits_d      = digits_q;
        blank_d       = blank_q;
        err_d         = err_q;
        frame_valid_d = 1'b0;
        scan_err_d    = 1'b0;
        capture       = 1'b0;
        seen_nxt      = seen_q | a;

        // Any movement on the synced lines restarts settling from every state.
        if (cur != prev_q) begin
            state_d = SETTLING;
            cnt_d   = '0;
        end else if (state_q == SETTLING) begin
            if (cnt_q == SETTLE_LAST) begin
                cnt_d   = SETTLE_C;
                state_d = IDLE;
                if (a == '0) begin
                    state_d = IDLE;
                end else if ((a & (a - ONE_HOT0)) != '0) begin
                    scan_err_d = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (a[i]) begin
                    digits_d[4*i +: 4] = dec_val;
                    blank_d[i]         = dec_blank;
                    err_d[i]           = dec_err;
                end
            end
            stall_d = '0;
            if (&seen_nxt) begin
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end else begin
                seen_d = seen_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '0;
            cnt_q         <= '0;
            stall_q       <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            blank_q       <= '1;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= {an, seg};
            sync2_q       <= sync1_q;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            stall_q       <= stall_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign err         = err_q;
    assign frame_valid = frame_valid_q;
    assign scan_err    = scan_err_q;
    assign stalled     = (stall_q == TIMEOUT_C);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits;
    logic [7:0]  blank, err;
    logic        frame_valid, scan_err, stalled;

    seg7_scan_decoder #(.DIGITS(8), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .an(an), .seg(seg), .digits(digits), .blank(blank),
        .err(err), .frame_valid(frame_valid), .scan_err(scan_err), .stalled(stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pos;
        logic [3:0] val;
        logic       bl;
        logic       er;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fv_cnt  = 0;
    int         se_cnt  = 0;
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (scan_err === 1'b1) se_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int pos, input logic [6:0] sv);
        logic [7:0] one;
        one = 8'd1 << pos;
        an  = ~one;
        seg = ~sv;
    endtask

    task automatic push_exp(input int pos, input logic [3:0] val, input logic bl, input logic er);
        exp_t e;
        e.pos = pos; e.val = val; e.bl = bl; e.er = er;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rstn = 1'b0; an = 8'hFF; seg = 7'h7F;
        tick(3);
        n_tests++; if (digits !== 32'h0) begin n_fail++; $display("FAIL reset_digits got=%h exp=%h", digits, 32'h0); end
        n_tests++; if (blank !== 8'hFF) begin n_fail++; $display("FAIL reset_blank got=%h exp=%h", blank, 8'hFF); end
        n_tests++; if (err !== 8'h00) begin n_fail++; $display("FAIL reset_err got=%h exp=%h", err, 8'h00); end
        n_tests++; if ({frame_valid, scan_err, stalled} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {frame_valid, scan_err, stalled}); end
        rstn = 1'b1;
        tick(3);
        n_tests++; if (blank !== 8'hFF) begin n_fail++; $display("FAIL post_reset_blank got=%h exp=%h", blank, 8'hFF); end
    endtask

    task automatic test_scan;
        exp_t e;
        int   fv0;
        fv0 = fv_cnt;
        for (int i = 0; i < 8; i++) begin
            push_exp(i, 4'(i), 1'b0, 1'b0);
            show(i, pat[i]);
            tick(SETTLE + 2);
            n_tests++; if (blank[i] !== 1'b1) begin n_fail++; $display("FAIL scan_early_capture pos=%0d blank got=%b exp=1", i, blank[i]); end
            tick(1);
            e = exp_q.pop_front();
            n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL scan_digit pos=%0d got=%h exp=%h", e.pos, digits[4*e.pos +: 4], e.val); end
            n_tests++; if ({blank[e.pos], err[e.pos]} !== {e.bl, e.er}) begin n_fail++; $display("FAIL scan_flags pos=%0d got=%b exp=%b", e.pos, {blank[e.pos], err[e.pos]}, {e.bl, e.er}); end
            n_tests++; if (frame_valid !== (i == 7)) begin n_fail++; $display("FAIL scan_frame_valid pos=%0d got=%b exp=%b", i, frame_valid, (i == 7)); end
            tick(10 - SETTLE - 3);
        end
        n_tests++; if (digits !== 32'h76543210) begin n_fail++; $display("FAIL scan_all_digits got=%h exp=%h", digits, 32'h76543210); end
        n_tests++; if ({blank, err} !== 16'h0) begin n_fail++; $display("FAIL scan_all_flags got=%h exp=0000", {blank, err}); end
        n_tests++; if (fv_cnt - fv0 !== 1) begin n_fail++; $display("FAIL scan_frame_count got=%0d exp=1", fv_cnt - fv0); end
    endtask

    task automatic test_glitch;
        exp_t e;
        logic saw_one;
        saw_one = 1'b0;
        push_exp(2, 4'hF, 1'b0, 1'b0);
        show(2, pat[15]);
        tick(SETTLE + 3);
        e = exp_q.pop_front();
        n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL glitch_pre got=%h exp=%h", digits[4*e.pos +: 4], e.val); end
        tick(2);
        show(2, 7'h06);
        for (int k = 0; k < 3; k++) begin tick(1); if (digits[11:8] == 4'h1) saw_one = 1'b1; end
        push_exp(2, 4'h2, 1'b0, 1'b0);
        show(2, pat[2]);
        for (int k = 0; k < SETTLE + 2; k++) begin tick(1); if (digits[11:8] == 4'h1) saw_one = 1'b1; end
        n_tests++; if (digits[11:8] !== 4'hF) begin n_fail++; $display("FAIL glitch_latency got=%h exp=f", digits[11:8]); end
        tick(1);
        e = exp_q.pop_front();
        n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL glitch_capture got=%h exp=%h", digits[4*e.pos +: 4], e.val); end
        for (int k = 0; k < 5; k++) begin tick(1); if (digits[11:8] == 4'h1) saw_one = 1'b1; end
        n_tests++; if (saw_one !== 1'b0) begin n_fail++; $display("FAIL glitch_captured_one got=%b exp=0", saw_one); end
    endtask

    task automatic test_invalid_blank;
        exp_t e;
        push_exp(3, 4'h0, 1'b0, 1'b1);
        show(3, 7'h55);
        tick(SETTLE + 3);
        e = exp_q.pop_front();
        n_tests++; if ({digits[4*e.pos +: 4], blank[e.pos], err[e.pos]} !== {e.val, e.bl, e.er}) begin n_fail++; $display("FAIL invalid_pos3 got=%h/%b%b exp=%h/%b%b", digits[4*e.pos +: 4], blank[e.pos], err[e.pos], e.val, e.bl, e.er); end
        tick(3);
        push_exp(4, 4'h0, 1'b1, 1'b0);
        show(4, 7'h00);
        tick(SETTLE + 3);
        e = exp_q.pop_front();
        n_tests++; if ({digits[4*e.pos +: 4], blank[e.pos], err[e.pos]} !== {e.val, e.bl, e.er}) begin n_fail++; $display("FAIL blank_pos4 got=%h/%b%b exp=%h/%b%b", digits[4*e.pos +: 4], blank[e.pos], err[e.pos], e.val, e.bl, e.er); end
        tick(3);
    endtask

    task automatic test_scan_err;
        logic [31:0] d0;
        logic [15:0] f0;
        int          se0, fv0;
        d0 = digits; f0 = {blank, err}; se0 = se_cnt; fv0 = fv_cnt;
        an = 8'hFC; seg = ~pat[8];
        tick(SETTLE + 2);
        n_tests++; if (scan_err !== 1'b0) begin n_fail++; $display("FAIL scan_err_early got=%b exp=0", scan_err); end
        tick(1);
        n_tests++; if (scan_err !== 1'b1) begin n_fail++; $display("FAIL scan_err_pulse got=%b exp=1", scan_err); end
        tick(10 - SETTLE - 3);
        n_tests++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL scan_err_count got=%0d exp=1", se_cnt - se0); end
        n_tests++; if ({digits, blank, err} !== {d0, f0}) begin n_fail++; $display("FAIL scan_err_state got=%h exp=%h", {digits, blank, err}, {d0, f0}); end
        n_tests++; if (fv_cnt !== fv0) begin n_fail++; $display("FAIL scan_err_frame got=%0d exp=%0d", fv_cnt, fv0); end
    endtask

    task automatic test_stall;
        exp_t e;
        push_exp(5, 4'hA, 1'b0, 1'b0);
        show(5, pat[10]);
        tick(SETTLE + 3);
        e = exp_q.pop_front();
        n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL stall_capture got=%h exp=%h", digits[4*e.pos +: 4], e.val); end
        tick(TIMEOUT - 1);
        n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL stall_early got=%b exp=0", stalled); end
        tick(1);
        n_tests++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL stall_assert got=%b exp=1", stalled); end
        tick(20);
        n_tests++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%b exp=1", stalled); end
        push_exp(6, 4'hB, 1'b0, 1'b0);
        show(6, pat[11]);
        tick(SETTLE + 3);
        e = exp_q.pop_front();
        n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL stall_recapture got=%h exp=%h", digits[4*e.pos +: 4], e.val); end
        tick(1);
        n_tests++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL stall_clear got=%b exp=0", stalled); end
    endtask

    task automatic test_reset_mid_frame;
        exp_t e;
        int   fv0;
        for (int i = 0; i < 5; i++) begin
            show(i, pat[i + 8]);
            tick(10);
        end
        show(7, pat[3]);
        tick(3);
        rstn = 1'b0;
        #1;
        n_tests++; if ({digits, blank, err} !== {32'h0, 8'hFF, 8'h00}) begin n_fail++; $display("FAIL midreset_outputs got=%h exp=%h", {digits, blank, err}, {32'h0, 8'hFF, 8'h00}); end
        n_tests++; if ({frame_valid, scan_err, stalled} !== 3'b000) begin n_fail++; $display("FAIL midreset_pulses got=%b exp=000", {frame_valid, scan_err, stalled}); end
        an = 8'hFF; seg = 7'h7F;
        tick(3);
        rstn = 1'b1;
        tick(3);
        fv0 = fv_cnt;
        for (int i = 7; i >= 0; i--) begin
            push_exp(i, 4'(15 - i), 1'b0, 1'b0);
            show(i, pat[15 - i]);
            tick(SETTLE + 3);
            e = exp_q.pop_front();
            n_tests++; if (digits[4*e.pos +: 4] !== e.val) begin n_fail++; $display("FAIL midreset_digit pos=%0d got=%h exp=%h", e.pos, digits[4*e.pos +: 4], e.val); end
            n_tests++; if (frame_valid !== (i == 0)) begin n_fail++; $display("FAIL midreset_frame pos=%0d got=%b exp=%b", i, frame_valid, (i == 0)); end
            tick(3);
        end
        n_tests++; if (fv_cnt - fv0 !== 1) begin n_fail++; $display("FAIL midreset_frame_count got=%0d exp=1", fv_cnt - fv0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_invalid_blank();
        test_scan_err();
        test_stall();
        test_reset_mid_frame();
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
